// File: rtl/fsqrt_iter.sv
// fsqrt_iter: iterative IEEE-754 single-precision square root.
//
// One operation in flight. An accepted operand is classified at once: specials
// (NaN, zero, denormal, negative, +inf) go straight to DONE. Normal operands
// run a restoring digit recurrence for 26 root bits (24 significand + guard +
// round), ITER_BITS bits per cycle. A single ROUND cycle follows, then DONE.
//
// Parameters
//   ITER_BITS  root bits resolved per CALC cycle (1 or 2)
//   TAG_W      width of the opaque tag carried from input to output
//
// Ports
//   clk          clock, all state on rising edge
//   rst          synchronous active-high reset
//   in_valid     operand offered
//   in_ready     block idle and able to accept
//   in_x         single-precision operand
//   in_rm        rounding mode: 0 = nearest-even, 1 = toward zero
//   in_tag       tag echoed on out_tag
//   out_valid    result presented (held until out_ready)
//   out_ready    consumer accepts result
//   out_y        sqrt(in_x)
//   out_tag      tag of the result
//   out_invalid  invalid-operation flag
//   out_inexact  inexact flag
module fsqrt_iter #(
  parameter int unsigned ITER_BITS = 1,
  parameter int unsigned TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic             in_rm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_invalid,
  output logic             out_inexact
);

  localparam int unsigned RootW     = 26;
  localparam int unsigned RadW      = 2 * RootW;
  // Partial remainder never exceeds 2*root+1 before the shift, so 30 bits is ample.
  localparam int unsigned RemW      = 30;
  localparam int unsigned CntW      = 5;
  localparam int unsigned NumCycles = RootW / ITER_BITS;

  localparam logic [CntW-1:0] CntLast  = CntW'(NumCycles - 1);
  localparam logic [31:0]     CanonNan = 32'h7FC0_0000;
  localparam logic [31:0]     PosInf   = 32'h7F80_0000;

  typedef enum logic [1:0] {StIdle, StCalc, StRound, StDone} state_e;

  state_e state_q, state_d;

  logic [RadW-1:0]  rad_q, rad_d;
  logic [RemW-1:0]  rem_q, rem_d;
  logic [RootW-1:0] root_q, root_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [7:0]       exp_q, exp_d;
  logic             rm_q, rm_d;

  logic [31:0]      out_y_q, out_y_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_inv_q, out_inv_d;
  logic             out_inx_q, out_inx_d;

  // ---------------------------------------------------------------------------
  // Operand classification
  // ---------------------------------------------------------------------------
  logic        x_sign;
  logic [7:0]  x_exp;
  logic [22:0] x_man;
  logic        is_special;
  logic [31:0] spec_y;
  logic        spec_inv;
  logic [8:0]  exp_sum;
  logic [7:0]  res_exp;
  logic [RadW-1:0] rad_init;

  assign x_sign = in_x[31];
  assign x_exp  = in_x[30:23];
  assign x_man  = in_x[22:0];

  always_comb begin
    is_special = 1'b1;
    spec_y     = '0;
    spec_inv   = 1'b0;
    if (x_exp == 8'hFF && x_man != '0) begin
      // Only a signalling NaN (quiet bit clear) raises invalid.
      spec_y   = CanonNan;
      spec_inv = ~x_man[22];
    end else if (x_exp == 8'h00) begin
      // Zeros and denormals both return a signed zero.
      spec_y = {x_sign, 31'b0};
    end else if (x_sign) begin
      spec_y   = CanonNan;
      spec_inv = 1'b1;
    end else if (x_exp == 8'hFF) begin
      spec_y = PosInf;
    end else begin
      is_special = 1'b0;
    end
  end

  // Unbiased exponent halves exactly when odd-biased; an even biased exponent
  // moves one factor of two into the radicand instead.
  assign exp_sum  = {1'b0, x_exp} + 9'd127;
  assign res_exp  = exp_sum[8:1];
  // Radicand scaled by 2^50 so the integer root carries 25 fractional bits.
  assign rad_init = x_exp[0] ? {1'b0, 1'b1, x_man, 27'b0} : {1'b1, x_man, 28'b0};

  // ---------------------------------------------------------------------------
  // Restoring recurrence: ITER_BITS steps per cycle
  // ---------------------------------------------------------------------------
  logic [RadW-1:0]  rad_nx;
  logic [RemW-1:0]  rem_nx;
  logic [RootW-1:0] root_nx;
  logic [RemW-1:0]  rem_sh;
  logic [RemW-1:0]  trial;

  always_comb begin
    rad_nx  = rad_q;
    rem_nx  = rem_q;
    root_nx = root_q;
    rem_sh  = '0;
    trial   = '0;
    for (int unsigned i = 0; i < ITER_BITS; i++) begin
      rem_sh = {rem_nx[RemW-3:0], rad_nx[RadW-1 -: 2]};
      trial  = {{(RemW - RootW - 2){1'b0}}, root_nx, 2'b01};
      if (rem_sh >= trial) begin
        rem_nx  = rem_sh - trial;
        root_nx = {root_nx[RootW-2:0], 1'b1};
      end else begin
        rem_nx  = rem_sh;
        root_nx = {root_nx[RootW-2:0], 1'b0};
      end
      rad_nx = {rad_nx[RadW-3:0], 2'b00};
    end
  end

  // ---------------------------------------------------------------------------
  // Rounding
  // ---------------------------------------------------------------------------
  logic        guard_bit;
  logic        sticky_bit;
  logic        lsb_bit;
  logic        round_up;
  logic [24:0] sig_rnd;
  logic [7:0]  rnd_exp;
  logic [22:0] rnd_man;
  logic [31:0] rnd_y;
  logic        rnd_inexact;

  assign guard_bit   = root_q[1];
  assign sticky_bit  = root_q[0] | (rem_q != '0);
  assign lsb_bit     = root_q[2];
  assign round_up    = ~rm_q & guard_bit & (sticky_bit | lsb_bit);
  assign sig_rnd     = {1'b0, root_q[RootW-1:2]} + {24'b0, round_up};
  // Carry out of the significand renormalises to 1.0 x 2^(e+1).
  assign rnd_exp     = exp_q + {7'b0, sig_rnd[24]};
  assign rnd_man     = sig_rnd[24] ? 23'b0 : sig_rnd[22:0];
  assign rnd_y       = {1'b0, rnd_exp, rnd_man};
  assign rnd_inexact = guard_bit | sticky_bit;

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    rad_d     = rad_q;
    rem_d     = rem_q;
    root_d    = root_q;
    cnt_d     = cnt_q;
    exp_d     = exp_q;
    rm_d      = rm_q;
    out_y_d   = out_y_q;
    out_tag_d = out_tag_q;
    out_inv_d = out_inv_q;
    out_inx_d = out_inx_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          out_tag_d = in_tag;
          if (is_special) begin
            out_y_d   = spec_y;
            out_inv_d = spec_inv;
            out_inx_d = 1'b0;
            state_d   = StDone;
          end else begin
            rm_d    = in_rm;
            exp_d   = res_exp;
            rad_d   = rad_init;
            rem_d   = '0;
            root_d  = '0;
            cnt_d   = CntLast;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        rad_d  = rad_nx;
        rem_d  = rem_nx;
        root_d = root_nx;
        if (cnt_q == '0) begin
          state_d = StRound;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRound: begin
        out_y_d   = rnd_y;
        out_inv_d = 1'b0;
        out_inx_d = rnd_inexact;
        state_d   = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      rad_q     <= '0;
      rem_q     <= '0;
      root_q    <= '0;
      cnt_q     <= '0;
      exp_q     <= '0;
      rm_q      <= 1'b0;
      out_y_q   <= '0;
      out_tag_q <= '0;
      out_inv_q <= 1'b0;
      out_inx_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rad_q     <= rad_d;
      rem_q     <= rem_d;
      root_q    <= root_d;
      cnt_q     <= cnt_d;
      exp_q     <= exp_d;
      rm_q      <= rm_d;
      out_y_q   <= out_y_d;
      out_tag_q <= out_tag_d;
      out_inv_q <= out_inv_d;
      out_inx_q <= out_inx_d;
    end
  end

  // Gating with rst keeps both handshakes dead while reset is held.
  assign in_ready    = (state_q == StIdle) && !rst;
  assign out_valid   = (state_q == StDone) && !rst;
  assign out_y       = out_y_q;
  assign out_tag     = out_tag_q;
  assign out_invalid = out_inv_q;
  assign out_inexact = out_inx_q;

endmodule

// File: doc/fsqrt_iter.md
FSQRT_ITER -- requirements
Module: fsqrt_iter

Interface
REQ-001 SHALL have parameter ITER_BITS, default 1, meaning root bits resolved per CALC cycle; legal values 1 or 2 only.
REQ-002 SHALL have parameter TAG_W, default 4, meaning the width of the opaque tag carried from input to output.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit, meaning operand offered.
REQ-006 SHALL have port in_ready, output, 1 bit, meaning the block can accept an operand.
REQ-007 SHALL have port in_x, input, 32 bits, meaning the IEEE-754 single-precision operand.
REQ-008 SHALL have port in_rm, input, 1 bit, meaning rounding mode: 0 = round-nearest-even, 1 = round-toward-zero.
REQ-009 SHALL have port in_tag, input, TAG_W bits, meaning a tag returned unchanged on out_tag.
REQ-010 SHALL have port out_valid, output, 1 bit, meaning a result is presented.
REQ-011 SHALL have port out_ready, input, 1 bit, meaning the consumer accepts the result.
REQ-012 SHALL have port out_y, output, 32 bits, meaning the single-precision sqrt(in_x).
REQ-013 SHALL have port out_tag, output, TAG_W bits, meaning the tag of the result.
REQ-014 SHALL have port out_invalid, output, 1 bit, meaning the IEEE invalid-operation flag.
REQ-015 SHALL have port out_inexact, output, 1 bit, meaning the IEEE inexact flag.

Function
REQ-016 SHALL implement the states IDLE, CALC, ROUND and DONE; in_ready = (state==IDLE) and rst is low.
REQ-017 SHALL make the accept condition in_valid&&in_ready at edge k, capturing in_x, in_rm and in_tag; later input changes are ignored until the next accept.
REQ-018 SHALL classify each operand at accept using the special-case rules in REQ-019 to REQ-023, in which case the block goes IDLE->DONE and out_valid is high from cycle k+1.
REQ-019 SHALL map a NaN input to the canonical NaN 0x7FC00000, with invalid=1 only for a signalling NaN (mantissa bit 22 = 0).
REQ-020 SHALL map a negative nonzero non-NaN input, including -inf, to 0x7FC00000 with invalid=1.
REQ-021 SHALL map +0 and -0 to themselves with the sign preserved.
REQ-022 SHALL treat denormal inputs as zero of the same sign, with no flags raised.
REQ-023 SHALL map +inf to 0x7F800000 with no flags raised.
REQ-024 SHALL, for a normal positive input with exponent field E, set the result exponent to (E+127)>>1 and the radicand to 1.m if E is odd or 2*(1.m) if E is even.
REQ-025 SHALL compute the root in CALC by restoring digit recurrence, ITER_BITS bits per cycle, 26 root bits in total (24 significand, guard, round), taking N=26/ITER_BITS cycles (26 or 13).
REQ-026 SHALL form sticky in ROUND as the round bit OR (remainder != 0), and set inexact = guard|sticky.
REQ-027 SHALL, under RNE, increment when guard && (sticky || lsb); under RTZ, truncate.
REQ-028 SHALL, on a significand carry-out, zero the mantissa and increment the exponent.
REQ-029 SHALL sequence the timing as CALC for cycles k+1..k+N, ROUND at k+N+1, and out_valid high from k+N+2 (k+28 for ITER_BITS=1, k+15 for ITER_BITS=2).
REQ-030 SHALL have DONE hold out_valid=1 and keep out_y, out_tag and flags stable until out_valid&&out_ready; the block then goes to IDLE next cycle.
REQ-031 SHALL keep in_ready low from accept until the cycle after the output handshake, so one operation is in flight and there is no back-to-back overlap.
REQ-032 SHALL never raise overflow or underflow, since the result is always normal or special.

Reset
REQ-033 SHALL, while rst is high at a clock edge, drive the state to IDLE and out_valid, out_y, out_tag, out_invalid, out_inexact and in_ready to 0.
REQ-034 SHALL, when rst is asserted mid-CALC, mid-ROUND or in DONE, abandon the operation and produce no result for it; in_ready rises the cycle after rst deasserts.
REQ-035 SHALL give rst priority over a simultaneous in_valid or out_ready.

Verification
REQ-036 SHALL cover in_x=0x40800000 (4.0), rm=0, ITER_BITS=1 -> out_y=0x40000000, inexact=0, invalid=0, out_valid at k+28.
REQ-037 SHALL cover in_x=0x40000000 (2.0) and 0x40400000 (3.0), rm=0 -> 0x3FB504F3 and 0x3FDDB3D7, inexact=1; repeat with ITER_BITS=2 -> same values at k+15.
REQ-038 SHALL cover specials 0x00000000, 0x80000000, 0x7F800000, 0xBF800000 and 0x7F800001 -> 0x00000000, 0x80000000, 0x7F800000, 0x7FC00000 (invalid=1) and 0x7FC00000 (invalid=1), each with out_valid at k+1.
REQ-039 SHALL cover backpressure: out_ready held low 5 cycles after out_valid -> out_y/out_tag stable and in_ready=0 throughout; in_ready=1 the cycle after the handshake.
REQ-040 SHALL cover rst pulsed at k+10 during CALC -> no out_valid for that operand; a new 0x40800000 accepted after reset returns 0x40000000 with the new tag.
